// File: rtl/csr_ring_master_if.sv
// Host request/response and CSR ring signals of csr_ring_master, plus a state debug tap.
// Handshake: a request transfers on a clk_csr edge with req_valid && req_ready; rsp_valid is a one-cycle pulse qualifying rsp_rd_data and rsp_timeout.
interface csr_ring_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wr_data;

    logic        rsp_valid;
    logic [63:0] rsp_rd_data;
    logic        rsp_timeout;

    logic [3:0]  ring_ctl_out;
    logic [15:0] ring_data_out;
    logic [3:0]  ring_ctl_in;
    logic [15:0] ring_data_in;

    logic [2:0]  dbg_state;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wr_data,
        input  ring_ctl_in,
        input  ring_data_in,
        output req_ready,
        output rsp_valid,
        output rsp_rd_data,
        output rsp_timeout,
        output ring_ctl_out,
        output ring_data_out,
        output dbg_state
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wr_data,
        output ring_ctl_in,
        output ring_data_in,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rd_data,
        input  rsp_timeout,
        input  ring_ctl_out,
        input  ring_data_out,
        input  dbg_state
    );
endinterface

// File: rtl/csr_ring_master.sv
// CSR ring master: turns one host read/write into command + DATA beats on the ring and waits for ACK/read data.
// Optional response-wait timeout is enabled by defining CSR_RING_MASTER_TIMEOUT_EN.
module csr_ring_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input logic               clk_csr,
    input logic               i_csr_reset_n,
    csr_ring_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CMD  = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_RECV_DATA = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [3:0] CTL_IDLE   = 4'h0;
    localparam logic [3:0] CTL_RD_CMD = 4'h1;
    localparam logic [3:0] CTL_WR_CMD = 4'h2;
    localparam logic [3:0] CTL_DATA   = 4'h3;
    localparam logic [3:0] CTL_ACK    = 4'h4;

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  beat_inc;
    logic [3:0]  ring_ctl_q, ring_ctl_d;
    logic [15:0] ring_data_q, ring_data_d;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_rd_data_q, rsp_rd_data_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        tmo_hit;

    assign beat_inc = beat_q + 2'd1;

`ifdef CSR_RING_MASTER_TIMEOUT_EN
    localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             waiting;

    // tmo_cnt_q is the number of cycles spent waiting, including the current one.
    assign waiting = (state_q == ST_WAIT_ACK) || (state_q == ST_RECV_DATA);
    assign tmo_hit = waiting && (tmo_cnt_q == TMO_LIMIT);

    always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
        if (!i_csr_reset_n) begin
            tmo_cnt_q <= '0;
        end else if ((state_d == ST_WAIT_ACK) && (state_q != ST_WAIT_ACK)) begin
            tmo_cnt_q <= TMO_W'(1);
        end else if (waiting) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state logic also computes the ring beat for the next cycle so the ring outputs are pure flops.
    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        wr_data_d     = wr_data_q;
        rd_data_d     = rd_data_q;
        beat_d        = beat_q;
        ring_ctl_d    = CTL_IDLE;
        ring_data_d   = '0;
        rsp_rd_data_d = '0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_ready_q && bus.req_valid) begin
                    is_write_d  = bus.req_write;
                    wr_data_d   = bus.req_wr_data;
                    ring_ctl_d  = bus.req_write ? CTL_WR_CMD : CTL_RD_CMD;
                    ring_data_d = bus.req_addr;
                    state_d     = ST_SEND_CMD;
                end
            end

            ST_SEND_CMD: begin
                if (is_write_q) begin
                    state_d     = ST_SEND_DATA;
                    beat_d      = 2'd0;
                    ring_ctl_d  = CTL_DATA;
                    ring_data_d = wr_data_q[15:0];
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end

            // beat_q is the index of the word on the ring this cycle.
            ST_SEND_DATA: begin
                if (beat_q == 2'd3) begin
                    state_d = ST_WAIT_ACK;
                end else begin
                    beat_d      = beat_inc;
                    ring_ctl_d  = CTL_DATA;
                    ring_data_d = wr_data_q[{beat_inc, 4'b0000} +: 16];
                end
            end

            ST_WAIT_ACK: begin
                if (tmo_hit) begin
                    state_d       = ST_DONE;
                    rsp_timeout_d = 1'b1;
                end else if (bus.ring_ctl_in == CTL_ACK) begin
                    if (is_write_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RECV_DATA;
                        beat_d    = 2'd0;
                        rd_data_d = '0;
                    end
                end
            end

            ST_RECV_DATA: begin
                if (tmo_hit) begin
                    state_d       = ST_DONE;
                    rsp_timeout_d = 1'b1;
                end else if (bus.ring_ctl_in == CTL_DATA) begin
                    rd_data_d[{beat_q, 4'b0000} +: 16] = bus.ring_data_in;
                    if (beat_q == 2'd3) begin
                        state_d       = ST_DONE;
                        rsp_rd_data_d = rd_data_d;
                    end else begin
                        beat_d = beat_inc;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // req_ready and rsp_valid follow the next state so they line up with IDLE and DONE.
    always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
        if (!i_csr_reset_n) begin
            state_q       <= ST_IDLE;
            is_write_q    <= 1'b0;
            wr_data_q     <= '0;
            rd_data_q     <= '0;
            beat_q        <= '0;
            ring_ctl_q    <= CTL_IDLE;
            ring_data_q   <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            wr_data_q     <= wr_data_d;
            rd_data_q     <= rd_data_d;
            beat_q        <= beat_d;
            ring_ctl_q    <= ring_ctl_d;
            ring_data_q   <= ring_data_d;
            req_ready_q   <= (state_d == ST_IDLE);
            rsp_valid_q   <= (state_d == ST_DONE);
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rd_data   = rsp_rd_data_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.ring_ctl_out  = ring_ctl_q;
    assign bus.ring_data_out = ring_data_q;
    assign bus.dbg_state     = state_q;

endmodule
